pwm_channel_scheduler: RTL

Drives the eight `uo_out`-style output pins from the SPI-written configuration registers. Runs two PWM generators with two duty-cycle channels each, all sharing one 8-bit period counter per generator, and routes any channel or static level to each pin. Duty and divider changes are double-buffered and applied only at the period boundary, so SPI writes never produce glitched or truncated pulses. Sits directly downstream of the SPI register bank, between it and the pad outputs.

---
 rtl/pwm_channel_scheduler_pkg.sv | 38 +++
 rtl/pwm_channel_scheduler_gen_core.sv | 146 ++++++++++++++
 rtl/pwm_channel_scheduler.sv | 110 +++++++++++
 3 files changed

// File: rtl/pwm_channel_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// pwm_channel_scheduler_pkg
// Shared definitions for the PWM channel scheduler:
//   - channel index constants used by the per-pin channel select
//   - shadow-register FSM state encoding
//   - PERIOD_MAX, the last counter value of a 256-tick period
//   - duty_level(), the duty comparator shared by both generators
// -----------------------------------------------------------------------------
package pwm_channel_scheduler_pkg;

    localparam logic [1:0] CH_G0C0 = 2'd0;
    localparam logic [1:0] CH_G0C1 = 2'd1;
    localparam logic [1:0] CH_G1C0 = 2'd2;
    localparam logic [1:0] CH_G1C1 = 2'd3;

    localparam logic [7:0] PERIOD_MAX = 8'd255;

    typedef enum logic [0:0] {
        SH_IDLE    = 1'b0,
        SH_PENDING = 1'b1
    } sh_state_e;

    // Duty 0 and duty 255 are pinned to constant levels so neither produces a
    // one-tick glitch at the period wrap; every other value is high for
    // exactly duty ticks per period.
    function automatic logic duty_level(input logic [7:0] cnt, input logic [7:0] duty);
        logic lvl;
        if (duty == 8'd0) begin
            lvl = 1'b0;
        end else if (duty == PERIOD_MAX) begin
            lvl = 1'b1;
        end else begin
            lvl = (cnt < duty);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/pwm_channel_scheduler_gen_core.sv
// -----------------------------------------------------------------------------
// pwm_gen_core
// One PWM generator: prescaler, 8-bit period counter, shadow-register FSM and
// two duty comparators. Live duty/exponent values are copied into the active
// registers only at the period wrap, so pulses are never truncated.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   div_live[3:0]     requested prescale exponent (tick every 2^div clocks)
//   duty_c0_live      requested duty, channel 0
//   duty_c1_live      requested duty, channel 1
//   cfg_strobe        pulse: duty or divider register was written
//   lvl_c0, lvl_c1    combinational channel levels (registered by the top)
//   period_start      registered pulse in the cycle the counter becomes 0
//   cfg_applied       registered pulse in the cycle new values become active
// -----------------------------------------------------------------------------
module pwm_gen_core
    import pwm_channel_scheduler_pkg::*;
#(
    parameter int PRESC_W = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] div_live,
    input  logic [7:0] duty_c0_live,
    input  logic [7:0] duty_c1_live,
    input  logic       cfg_strobe,
    output logic       lvl_c0,
    output logic       lvl_c1,
    output logic       period_start,
    output logic       cfg_applied
);

    localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};

    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_lim_s;
    logic [7:0]         cnt_r;
    logic [3:0]         div_r;
    logic [7:0]         duty_c0_r;
    logic [7:0]         duty_c1_r;
    logic               tick_s;
    logic               wrap_s;
    logic               load_s;
    logic               period_start_r;
    logic               cfg_applied_r;
    sh_state_e          state_r;
    sh_state_e          state_nxt_s;

    // Tick and wrap decode; the limit 2^div-1 relies on modular wrap so that
    // div == PRESC_W still yields an all-ones limit.
    always_comb begin
        presc_lim_s = (PRESC_ONE << div_r) - PRESC_ONE;
        tick_s      = (presc_r == presc_lim_s);
        wrap_s      = tick_s && (cnt_r == PERIOD_MAX);
    end

    // Shadow FSM next state; a strobe coinciding with the load keeps the
    // update pending so the next wrap reloads whatever was written last.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            SH_IDLE: begin
                if (cfg_strobe) begin
                    state_nxt_s = SH_PENDING;
                end else begin
                    state_nxt_s = SH_IDLE;
                end
            end
            SH_PENDING: begin
                if (wrap_s) begin
                    load_s = 1'b1;
                    if (cfg_strobe) begin
                        state_nxt_s = SH_PENDING;
                    end else begin
                        state_nxt_s = SH_IDLE;
                    end
                end else begin
                    state_nxt_s = SH_PENDING;
                end
            end
            default: begin
                state_nxt_s = SH_IDLE;
            end
        endcase
    end

    // Shadow FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SH_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Prescaler and period counter; the exponent only changes at a wrap, where
    // the prescaler is already 0, so no partial tick can occur.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= PRESC_ZERO;
            cnt_r   <= 8'd0;
        end else if (tick_s) begin
            presc_r <= PRESC_ZERO;
            cnt_r   <= cnt_r + 8'd1;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
            cnt_r   <= cnt_r;
        end
    end

    // Active duty/exponent registers, loaded from the live inputs at the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r     <= 4'd0;
            duty_c0_r <= 8'd0;
            duty_c1_r <= 8'd0;
        end else if (load_s) begin
            div_r     <= div_live;
            duty_c0_r <= duty_c0_live;
            duty_c1_r <= duty_c1_live;
        end else begin
            div_r     <= div_r;
            duty_c0_r <= duty_c0_r;
            duty_c1_r <= duty_c1_r;
        end
    end

    // Status pulses, aligned with the cycle in which the counter reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_start_r <= 1'b0;
            cfg_applied_r  <= 1'b0;
        end else begin
            period_start_r <= wrap_s;
            cfg_applied_r  <= load_s;
        end
    end

    assign lvl_c0       = duty_level(cnt_r, duty_c0_r);
    assign lvl_c1       = duty_level(cnt_r, duty_c1_r);
    assign period_start = period_start_r;
    assign cfg_applied  = cfg_applied_r;

endmodule

// File: rtl/pwm_channel_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_channel_scheduler
// Two PWM generators (two duty channels each) routed to eight output pins.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en_out[7:0]              per-pin enable (0 forces the pin low)
//   en_pwm_out[7:0]          per-pin mode (1 = PWM channel, 0 = static high)
//   out_3_0_sel, out_7_4_sel 2-bit channel select per pin
//   duty_g0c0..duty_g1c1     requested duty values
//   freq_div[7:0]            [3:0] gen0 exponent, [7:4] gen1 exponent
//   cfg_strobe               pulse when a duty or divider register is written
//   pwm_out[7:0]             registered pin outputs
//   period_start[1:0]        per-generator wrap pulse
//   cfg_applied[1:0]         per-generator shadow-load pulse
// -----------------------------------------------------------------------------
module pwm_channel_scheduler
    import pwm_channel_scheduler_pkg::*;
#(
    parameter int PRESC_W = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] en_out,
    input  logic [7:0] en_pwm_out,
    input  logic [7:0] out_3_0_sel,
    input  logic [7:0] out_7_4_sel,
    input  logic [7:0] duty_g0c0,
    input  logic [7:0] duty_g0c1,
    input  logic [7:0] duty_g1c0,
    input  logic [7:0] duty_g1c1,
    input  logic [7:0] freq_div,
    input  logic       cfg_strobe,
    output logic [7:0] pwm_out,
    output logic [1:0] period_start,
    output logic [1:0] cfg_applied
);

    logic        g0_lvl_c0_s;
    logic        g0_lvl_c1_s;
    logic        g1_lvl_c0_s;
    logic        g1_lvl_c1_s;
    logic [15:0] sel_all_s;
    logic [1:0]  sel_s;
    logic        lvl_s;
    logic [7:0]  pin_nxt_s;
    logic [7:0]  pwm_out_r;

    pwm_gen_core #(.PRESC_W(PRESC_W)) u_gen0 (
        .clk          (clk),
        .rst          (rst),
        .div_live     (freq_div[3:0]),
        .duty_c0_live (duty_g0c0),
        .duty_c1_live (duty_g0c1),
        .cfg_strobe   (cfg_strobe),
        .lvl_c0       (g0_lvl_c0_s),
        .lvl_c1       (g0_lvl_c1_s),
        .period_start (period_start[0]),
        .cfg_applied  (cfg_applied[0])
    );

    pwm_gen_core #(.PRESC_W(PRESC_W)) u_gen1 (
        .clk          (clk),
        .rst          (rst),
        .div_live     (freq_div[7:4]),
        .duty_c0_live (duty_g1c0),
        .duty_c1_live (duty_g1c1),
        .cfg_strobe   (cfg_strobe),
        .lvl_c0       (g1_lvl_c0_s),
        .lvl_c1       (g1_lvl_c1_s),
        .period_start (period_start[1]),
        .cfg_applied  (cfg_applied[1])
    );

    // Per-pin mux: enable, then static/PWM mode, then channel select.
    always_comb begin
        sel_all_s = {out_7_4_sel, out_3_0_sel};
        sel_s     = 2'd0;
        lvl_s     = 1'b0;
        pin_nxt_s = 8'd0;
        for (int n = 0; n < 8; n++) begin
            sel_s = sel_all_s[2*n +: 2];
            case (sel_s)
                CH_G0C0: lvl_s = g0_lvl_c0_s;
                CH_G0C1: lvl_s = g0_lvl_c1_s;
                CH_G1C0: lvl_s = g1_lvl_c0_s;
                CH_G1C1: lvl_s = g1_lvl_c1_s;
                default: lvl_s = 1'b0;
            endcase
            if (!en_out[n]) begin
                pin_nxt_s[n] = 1'b0;
            end else if (!en_pwm_out[n]) begin
                pin_nxt_s[n] = 1'b1;
            end else begin
                pin_nxt_s[n] = lvl_s;
            end
        end
    end

    // Pin output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out_r <= 8'd0;
        end else begin
            pwm_out_r <= pin_nxt_s;
        end
    end

    assign pwm_out = pwm_out_r;

endmodule
